// File: rtl/sudoku_pkg.sv
// Shared definitions for the 4x4 sudoku game: row word layout, loader FSM
// states and the built-in starting puzzles.
package sudoku_pkg;

  localparam int ROW_W         = 20;
  localparam int CELL_W        = 4;
  localparam int TABLE_ROWS    = 4;
  localparam int TABLE_PUZZLES = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WRITE,
    VERIFY,
    DONE
  } loadState_t;

  // Cell nibbles of every puzzle row, 16 bits per row. Puzzle 0 row 0 sits
  // in the least significant slot; a zero nibble is an empty cell.
  localparam logic [TABLE_PUZZLES*TABLE_ROWS*16-1:0] PUZZLE_CELLS = {
    16'h0013, 16'h3000, 16'h0002, 16'h2300,   // puzzle 3, rows 3..0
    16'h3400, 16'h0003, 16'h1000, 16'h0041,   // puzzle 2
    16'h0030, 16'h4002, 16'h3001, 16'h0200,   // puzzle 1
    16'h0320, 16'h2003, 16'h0410, 16'h1004    // puzzle 0
  };

  // Cell nibbles of one row of one puzzle.
  function automatic logic [15:0] puzzleCells(input logic [1:0] puzzle,
                                              input logic [1:0] row);
    return PUZZLE_CELLS[{puzzle, row, 4'b0000} +: 16];
  endfunction

  // Full RAM word: a given (nonzero) cell c is protected by bit 19-c.
  function automatic logic [ROW_W-1:0] buildRow(input logic [15:0] cells);
    logic [3:0] protect;
    protect = '0;
    for (int c = 0; c < 4; c++) begin
      protect[3-c] = |cells[(3-c)*CELL_W +: CELL_W];
    end
    return {protect, cells};
  endfunction

endpackage

// File: rtl/puzzle_rom.sv
// Combinational lookup of a complete row word for (puzzle, row).
module puzzle_rom
  import sudoku_pkg::*;
(
  input  logic [1:0]       puzzle,
  input  logic [1:0]       row,
  output logic [ROW_W-1:0] word
);

  // Table cells plus protect bits derived from them.
  always_comb begin
    word = buildRow(puzzleCells(puzzle, row));
  end

endmodule

// File: rtl/puzzle_loader.sv
// Loads a starting puzzle into game RAM port A, then reads every row back
// and flags any mismatch. Port A is shared, so every access waits on ramGnt.
module puzzle_loader
  import sudoku_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int NUM_PUZZLES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             newGame,
  input  logic [1:0]       puzzleSel,
  input  logic             ramGnt,
  input  logic [ROW_W-1:0] ramQ,
  output logic             ramReq,
  output logic [1:0]       ramAddr,
  output logic [ROW_W-1:0] ramData,
  output logic             ramWren,
  output logic             busy,
  output logic             loadDone,
  output logic             loadError
);

  // Completion is decided on the terminal count, never on counter wrap.
  localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);

  loadState_t       stateReg, stateNext;
  logic [1:0]       selReg, selNext;
  logic [1:0]       rowReg, rowNext;
  logic [1:0]       issueReg, issueNext;
  logic             issuedAllReg, issuedAllNext;
  logic [1:0]       cmpRowReg, cmpRowNext;
  logic             cmpVldReg, cmpVldNext;
  logic             busyReg, busyNext;
  logic             loadDoneReg, loadDoneNext;
  logic             loadErrorReg, loadErrorNext;
  logic [ROW_W-1:0] writeWord, expectWord;

  // One lookup for the word being written, one for the word being checked.
  puzzle_rom uWriteRom (
    .puzzle (selReg),
    .row    (rowReg),
    .word   (writeWord)
  );

  puzzle_rom uExpectRom (
    .puzzle (selReg),
    .row    (cmpRowReg),
    .word   (expectWord)
  );

  // State, counters and registered flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stateReg     <= IDLE;
      selReg       <= '0;
      rowReg       <= '0;
      issueReg     <= '0;
      issuedAllReg <= 1'b0;
      cmpRowReg    <= '0;
      cmpVldReg    <= 1'b0;
      busyReg      <= 1'b0;
      loadDoneReg  <= 1'b0;
      loadErrorReg <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      selReg       <= selNext;
      rowReg       <= rowNext;
      issueReg     <= issueNext;
      issuedAllReg <= issuedAllNext;
      cmpRowReg    <= cmpRowNext;
      cmpVldReg    <= cmpVldNext;
      busyReg      <= busyNext;
      loadDoneReg  <= loadDoneNext;
      loadErrorReg <= loadErrorNext;
    end
  end

  // Next-state logic: write four rows, then issue four reads and compare each
  // one cycle later. A pending compare completes even while the grant is low.
  always_comb begin
    stateNext     = stateReg;
    selNext       = selReg;
    rowNext       = rowReg;
    issueNext     = issueReg;
    issuedAllNext = issuedAllReg;
    cmpRowNext    = cmpRowReg;
    cmpVldNext    = 1'b0;
    busyNext      = busyReg;
    loadDoneNext  = 1'b0;
    loadErrorNext = loadErrorReg;
    case (stateReg)
      IDLE: begin
        if (newGame) begin
          // An index beyond the table falls back to puzzle 0.
          selNext       = (int'(puzzleSel) < NUM_PUZZLES) ? puzzleSel : 2'd0;
          loadErrorNext = 1'b0;
          busyNext      = 1'b1;
          stateNext     = REQ;
        end
      end
      REQ: begin
        if (ramGnt) begin
          rowNext   = 2'd0;
          stateNext = WRITE;
        end
      end
      WRITE: begin
        if (ramGnt) begin
          rowNext = rowReg + 2'd1;
          if (rowReg == LAST_ROW) begin
            issueNext     = 2'd0;
            issuedAllNext = 1'b0;
            stateNext     = VERIFY;
          end
        end
      end
      VERIFY: begin
        if (ramGnt && !issuedAllReg) begin
          cmpVldNext = 1'b1;
          cmpRowNext = issueReg;
          issueNext  = issueReg + 2'd1;
          if (issueReg == LAST_ROW) begin
            issuedAllNext = 1'b1;
          end
        end
        if (cmpVldReg) begin
          if (ramQ != expectWord) begin
            loadErrorNext = 1'b1;
          end
          if (cmpRowReg == LAST_ROW) begin
            loadDoneNext = 1'b1;
            stateNext    = DONE;
          end
        end
      end
      DONE: begin
        busyNext  = 1'b0;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Port A drive: the write strobe is the write phase qualified by the grant,
  // so a stalled cycle never writes; address and data decode from state.
  always_comb begin
    ramWren = (stateReg == WRITE) && ramGnt;
    ramData = (stateReg == WRITE) ? writeWord : '0;
    case (stateReg)
      WRITE:   ramAddr = rowReg;
      VERIFY:  ramAddr = issueReg;
      default: ramAddr = 2'd0;
    endcase
  end

  assign ramReq    = busyReg;
  assign busy      = busyReg;
  assign loadDone  = loadDoneReg;
  assign loadError = loadErrorReg;

endmodule
